dmem_responder: RTL and testbench

Data-memory responder for the 5-stage pipelined processor: the slave end of the processor's `address_dmem`/`data`/`wren`/`q_dmem` port. Serves word-addressed RAM plus three memory-mapped I/O registers: an 8-bit transmit FIFO with a valid/ready drain port, its status word, and a free-running cycle counter. Instantiated in the wrapper in place of the bare dmem.

---
 rtl/dmem_responder.sv | 131 +++++++++++++
 tb/tb_dmem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory slave: word RAM plus TXDATA/STATUS/CYCLES registers, 1-cycle registered reads.
// TX FIFO drains on valid/ready; a push into a full FIFO without a same-cycle pop is dropped and flagged.
module dmem_responder #(
    parameter int ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [7:0]  io_tx_data,
    output logic        io_tx_valid,
    input  logic        io_tx_ready
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_0004;
    localparam logic [31:0] CYCLES_ADDR = 32'hFFFF_0008;

    logic                  is_ram;
    logic                  is_tx;
    logic                  is_status;
    logic                  is_cycles;
    logic [ADDR_WIDTH-1:0] ram_idx;

    assign is_ram    = (address_dmem >> ADDR_WIDTH) == 32'd0;
    assign is_tx     = address_dmem == TXDATA_ADDR;
    assign is_status = address_dmem == STATUS_ADDR;
    assign is_cycles = address_dmem == CYCLES_ADDR;
    assign ram_idx   = address_dmem[ADDR_WIDTH-1:0];

    // RAM: no reset, read-first on a same-word write.
    logic [31:0] ram [2**ADDR_WIDTH];
    logic [31:0] ram_q;

    always_ff @(posedge clock) begin
        if (wren && is_ram) begin
            ram[ram_idx] <= data;
        end
        ram_q <= ram[ram_idx];
    end

    // TX FIFO
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [31:0]   cycles;
    logic          full;
    logic          pop;
    logic          push_req;
    logic          push_ok;

    assign full        = count == CW'(FIFO_DEPTH);
    assign io_tx_valid = count != '0;
    assign io_tx_data  = io_tx_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign pop         = io_tx_valid && io_tx_ready;
    assign push_req    = wren && is_tx;
    assign push_ok     = push_req && (!full || pop);

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= data[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            cycles <= 32'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push_ok) begin
                count <= count - CW'(1);
            end
            // A STATUS write clears the flag even if a rejected push lands on the same edge.
            if (wren && is_status) begin
                ovf <= 1'b0;
            end else if (push_req && !push_ok) begin
                ovf <= 1'b1;
            end
            if (wren && is_cycles) begin
                cycles <= data;
            end else begin
                cycles <= cycles + 32'd1;
            end
        end
    end

    // Read path: IO value and RAM/IO select are registered; RAM data comes from ram_q.
    logic [31:0] io_rdata;
    logic [31:0] io_q;
    logic        ram_sel;

    always_comb begin
        io_rdata = 32'd0;
        if (is_tx) begin
            io_rdata = {24'd0, io_tx_data};
        end else if (is_status) begin
            io_rdata = {ovf, 23'd0, 8'(count)};
        end else if (is_cycles) begin
            io_rdata = cycles;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_q    <= 32'd0;
            ram_sel <= 1'b0;
        end else begin
            io_q    <= io_rdata;
            ram_sel <= is_ram;
        end
    end

    assign q_dmem = ram_sel ? ram_q : io_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a queue/array reference model checked every cycle.
module tb_dmem_responder;
    localparam logic [31:0] TX   = 32'hFFFF_0000;
    localparam logic [31:0] ST   = 32'hFFFF_0004;
    localparam logic [31:0] CY   = 32'hFFFF_0008;
    localparam logic [31:0] IDLE = 32'h0000_2000;
    localparam int          DEPTH = 8;

    logic        clock;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [7:0]  io_tx_data;
    logic        io_tx_valid;
    logic        io_tx_ready;

    dmem_responder #(.ADDR_WIDTH(12), .FIFO_DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .io_tx_data   (io_tx_data),
        .io_tx_valid  (io_tx_valid),
        .io_tx_ready  (io_tx_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model state
    logic [31:0] m_ram [int];
    logic [7:0]  m_fifo [$];
    logic        m_ovf;
    logic [31:0] m_cyc;
    logic [31:0] exp_q;
    logic        exp_q_known;
    logic        exp_valid;
    logic [7:0]  exp_txd;
    logic        chk_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic model_reset();
        m_fifo.delete();
        m_ovf       = 1'b0;
        m_cyc       = 32'd0;
        exp_q       = 32'd0;
        exp_q_known = 1'b1;
        exp_valid   = 1'b0;
        exp_txd     = 8'h00;
    endtask

    // One rising edge of the memory map, expressed from the register rules.
    task automatic model_step();
        logic [31:0] a;
        int          sz;
        logic        pop;
        a  = address_dmem;
        sz = m_fifo.size();
        exp_q_known = 1'b1;
        if (a < 32'd4096) begin
            if (m_ram.exists(int'(a))) exp_q = m_ram[int'(a)];
            else exp_q_known = 1'b0;
        end else if (a == TX) begin
            exp_q = (sz > 0) ? {24'd0, m_fifo[0]} : 32'd0;
        end else if (a == ST) begin
            exp_q = {m_ovf, 23'd0, 8'(sz)};
        end else if (a == CY) begin
            exp_q = m_cyc;
        end else begin
            exp_q = 32'd0;
        end
        pop = (sz > 0) && io_tx_ready;
        if (pop) void'(m_fifo.pop_front());
        if (wren && a == TX) begin
            if (sz < DEPTH || pop) m_fifo.push_back(data[7:0]);
            else m_ovf = 1'b1;
        end
        if (wren && a == ST) m_ovf = 1'b0;
        if (wren && a < 32'd4096) m_ram[int'(a)] = data;
        m_cyc = (wren && a == CY) ? data : m_cyc + 32'd1;
        exp_valid = m_fifo.size() != 0;
        exp_txd   = exp_valid ? m_fifo[0] : 8'h00;
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            if (exp_q_known) chk("q_dmem", q_dmem, exp_q);
            chk("tx_valid", {31'd0, io_tx_valid}, {31'd0, exp_valid});
            chk("tx_data", {24'd0, io_tx_data}, {24'd0, exp_txd});
        end
    end

    task automatic cyc(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        address_dmem = a;
        data         = d;
        wren         = w;
        io_tx_ready  = r;
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    initial begin
        logic [7:0] seq [8];
        chk_en       = 1'b0;
        reset        = 1'b0;
        address_dmem = 32'd0;
        data         = 32'd0;
        wren         = 1'b0;
        io_tx_ready  = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        chk("rst_q", q_dmem, 32'd0);
        chk("rst_valid", {31'd0, io_tx_valid}, 32'd0);
        chk("rst_txd", {24'd0, io_tx_data}, 32'd0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // RAM write/read, read-first, boundaries, no aliasing above the RAM
        cyc(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
        cyc(32'd5, 32'd0, 1'b0, 1'b0);
        chk("ram_rd", q_dmem, 32'hDEAD_BEEF);
        cyc(32'd5, 32'h1, 1'b1, 1'b0);
        chk("ram_rfirst", q_dmem, 32'hDEAD_BEEF);
        cyc(32'd5, 32'd0, 1'b0, 1'b0);
        chk("ram_new", q_dmem, 32'h1);
        cyc(32'd0, 32'h1234_5678, 1'b1, 1'b0);
        cyc(32'd4095, 32'hCAFE_F00D, 1'b1, 1'b0);
        cyc(32'd4096, 32'h0BAD_0BAD, 1'b1, 1'b0);
        cyc(32'd0, 32'd0, 1'b0, 1'b0);
        chk("ram_noalias", q_dmem, 32'h1234_5678);
        cyc(32'd4095, 32'd0, 1'b0, 1'b0);
        chk("ram_top", q_dmem, 32'hCAFE_F00D);
        cyc(32'hFFFF_000C, 32'h5, 1'b1, 1'b0);
        cyc(32'hFFFF_000C, 32'd0, 1'b0, 1'b0);
        chk("unmapped", q_dmem, 32'd0);

        // Fill and overflow with the consumer stalled
        for (int i = 0; i < 9; i++) cyc(TX, 32'h11 + i, 1'b1, 1'b0);
        cyc(ST, 32'd0, 1'b0, 1'b0);
        chk("st_ovf", q_dmem, 32'h8000_0008);
        chk("head_held", {24'd0, io_tx_data}, 32'h11);
        cyc(TX, 32'd0, 1'b0, 1'b0);
        chk("txdata_rd", q_dmem, 32'h11);
        cyc(ST, 32'd0, 1'b1, 1'b0);
        cyc(ST, 32'd0, 1'b0, 1'b0);
        chk("st_clr", q_dmem, 32'h0000_0008);

        // Drain in order
        for (int i = 0; i < 8; i++) begin
            chk("drain", {24'd0, io_tx_data}, 32'h11 + i);
            cyc(IDLE, 32'd0, 1'b0, 1'b1);
        end
        chk("drain_empty", {31'd0, io_tx_valid}, 32'd0);
        cyc(ST, 32'd0, 1'b0, 1'b0);
        chk("st_empty", q_dmem, 32'd0);

        // Push into a full FIFO while popping
        for (int i = 0; i < 8; i++) cyc(TX, 32'h21 + i, 1'b1, 1'b0);
        cyc(TX, 32'hAA, 1'b1, 1'b1);
        cyc(ST, 32'd0, 1'b0, 1'b0);
        chk("st_full_pp", q_dmem, 32'h0000_0008);
        for (int i = 0; i < 7; i++) seq[i] = 8'h22 + 8'(i);
        seq[7] = 8'hAA;
        for (int i = 0; i < 8; i++) begin
            chk("pp_order", {24'd0, io_tx_data}, {24'd0, seq[i]});
            cyc(IDLE, 32'd0, 1'b0, 1'b1);
        end

        // Counter load and wrap
        cyc(CY, 32'hFFFF_FFFE, 1'b1, 1'b0);
        cyc(CY, 32'd0, 1'b0, 1'b0);
        chk("cyc0", q_dmem, 32'hFFFF_FFFE);
        cyc(CY, 32'd0, 1'b0, 1'b0);
        chk("cyc1", q_dmem, 32'hFFFF_FFFF);
        cyc(CY, 32'd0, 1'b0, 1'b0);
        chk("cyc_wrap", q_dmem, 32'd0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) cyc(TX, 32'h31 + i, 1'b1, 1'b0);
        cyc(32'd5, 32'd0, 1'b0, 1'b0);
        chk("pre_rst_q", q_dmem, 32'h1);
        chk_en = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, io_tx_valid}, 32'd0);
        chk("arst_q", q_dmem, 32'd0);
        chk("arst_txd", {24'd0, io_tx_data}, 32'd0);
        repeat (2) @(negedge clock);
        model_reset();
        reset  = 1'b1;
        chk_en = 1'b1;
        cyc(ST, 32'd0, 1'b0, 1'b0);
        chk("post_rst_st", q_dmem, 32'd0);
        cyc(CY, 32'd0, 1'b0, 1'b0);
        chk("post_rst_cyc", q_dmem, 32'd1);
        cyc(32'd5, 32'd0, 1'b0, 1'b0);
        chk("ram_keeps", q_dmem, 32'h1);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
